alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_multicycle_if.sv | 24 ++
 rtl/alu_mul_iter.sv | 47 ++++
 rtl/alu_multicycle.sv | 167 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the multi-cycle ALU, plus the clog2 helper
// used to size shift and iteration counters.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_FWD = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SLL = 3'b100,
      OP_SRL = 3'b101,
      OP_SRA = 3'b110,
      OP_MUL = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 32;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between an ALU client (master) and alu_multicycle (slave).
interface alu_multicycle_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic [2:0]       SELECT;
   logic [WIDTH-1:0] DATA1;
   logic [WIDTH-1:0] DATA2;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] RESULT;
   logic             ZERO;
   logic             OVERFLOW;

   modport master (
      output START, SELECT, DATA1, DATA2,
      input  BUSY, DONE, RESULT, ZERO, OVERFLOW
   );

   modport slave (
      input  START, SELECT, DATA1, DATA2,
      output BUSY, DONE, RESULT, ZERO, OVERFLOW
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// Only the low WIDTH product bits are kept, which are identical for signed and unsigned operands.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] product
);
   localparam int SHW = clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [SHW-1:0]   cnt_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
      end else if (load) begin
         acc_reg    <= '0;
         mcand_reg  <= a;
         mplier_reg <= b;
         cnt_reg    <= SHW'(WIDTH);
      end else if (cnt_reg != '0) begin
         if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
         end
         mcand_reg  <= {mcand_reg[WIDTH-2:0], 1'b0};
         mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
         cnt_reg    <= cnt_reg - SHW'(1);
      end
   end

   assign busy    = (cnt_reg != '0);
   assign product = acc_reg;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts and an iterative
// multiplier, sequenced by an IDLE/EXEC/FINISH controller with a one-cycle DONE pulse.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   alu_multicycle_if.slave bus
);
   localparam int SHW = clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("alu_multicycle: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
   end

   state_t           state_reg, state_next;
   op_t              op_reg, op_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [SHW-1:0]   shamt_reg, shamt_next;
   logic [SHW-1:0]   iter_reg, iter_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             zero_reg, zero_next;
   logic             ovf_reg, ovf_next;

   logic             accept;
   logic [SHW-1:0]   shamt_sat;
   logic [WIDTH-1:0] sum;
   logic             add_ovf;
   logic [WIDTH-1:0] shift_one;
   logic             is_shift;
   logic             last_exec;
   logic             mul_load;
   logic             mul_busy;
   logic [WIDTH-1:0] mul_product;

   assign accept    = (state_reg == ST_IDLE) && bus.START;
   assign shamt_sat = (bus.DATA2 >= WIDTH_V) ? SHW'(WIDTH) : bus.DATA2[SHW-1:0];
   assign sum       = a_reg + b_reg;
   assign add_ovf   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
   assign is_shift  = (op_reg == OP_SLL) || (op_reg == OP_SRL) || (op_reg == OP_SRA);
   // The multiplier is loaded straight from the bus on the accepting edge so it
   // starts iterating in the first EXEC cycle.
   assign mul_load  = accept && (op_t'(bus.SELECT) == OP_MUL);
   assign last_exec = (op_reg == OP_MUL) ? !mul_busy : (iter_reg == SHW'(1));

   always_comb begin
      shift_one = a_reg;
      case (op_reg)
         OP_SLL:  shift_one = {a_reg[WIDTH-2:0], 1'b0};
         OP_SRL:  shift_one = {1'b0, a_reg[WIDTH-1:1]};
         OP_SRA:  shift_one = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
         default: shift_one = a_reg;
      endcase
   end

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .CLK     (CLK),
      .RESET   (RESET),
      .load    (mul_load),
      .a       (bus.DATA1),
      .b       (bus.DATA2),
      .busy    (mul_busy),
      .product (mul_product)
   );

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      shamt_next  = shamt_reg;
      iter_next   = iter_reg;
      result_next = result_reg;
      zero_next   = zero_reg;
      ovf_next    = ovf_reg;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_EXEC;
               op_next    = op_t'(bus.SELECT);
               a_next     = bus.DATA1;
               b_next     = bus.DATA2;
               shamt_next = shamt_sat;
               iter_next  = SHW'(1);
               // A zero-count shift still occupies one EXEC cycle.
               if (bus.SELECT[2] && (bus.SELECT != 3'b111) && (shamt_sat != '0)) begin
                  iter_next = shamt_sat;
               end
            end
         end

         ST_EXEC: begin
            if (is_shift && (shamt_reg != '0)) begin
               a_next     = shift_one;
               shamt_next = shamt_reg - SHW'(1);
            end
            if (iter_reg != '0) begin
               iter_next = iter_reg - SHW'(1);
            end
            if (last_exec) begin
               state_next = ST_FINISH;
               ovf_next   = 1'b0;
               case (op_reg)
                  OP_FWD:  result_next = b_reg;
                  OP_ADD: begin
                     result_next = sum;
                     ovf_next    = add_ovf;
                  end
                  OP_AND:  result_next = a_reg & b_reg;
                  OP_OR:   result_next = a_reg | b_reg;
                  OP_MUL:  result_next = mul_product;
                  default: result_next = a_next;
               endcase
               zero_next = (result_next == '0);
            end
         end

         ST_FINISH: state_next = ST_IDLE;

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         op_reg     <= OP_FWD;
         a_reg      <= '0;
         b_reg      <= '0;
         shamt_reg  <= '0;
         iter_reg   <= '0;
         result_reg <= '0;
         zero_reg   <= 1'b1;
         ovf_reg    <= 1'b0;
      end else begin
         op_reg     <= op_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         shamt_reg  <= shamt_next;
         iter_reg   <= iter_next;
         result_reg <= result_next;
         zero_reg   <= zero_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign bus.BUSY     = (state_reg != ST_IDLE);
   assign bus.DONE     = (state_reg == ST_FINISH);
   assign bus.RESULT   = result_reg;
   assign bus.ZERO     = zero_reg;
   assign bus.OVERFLOW = ovf_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a latency/result model checked every cycle,
// plus literal expectations per operation.
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int W    = 8;
   localparam int SMAX = (2 ** (W - 1)) - 1;
   localparam int SMIN = -(2 ** (W - 1));

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   chk_en = 0;

   alu_multicycle_if #(.WIDTH(W)) bus ();

   alu_multicycle #(.WIDTH(W)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operation semantics from first principles: result, overflow flag and the
   // number of cycles from the accepting edge to the edge that samples DONE.
   function automatic void model_op(input logic [2:0] sel, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] r,
                                    output logic o, output int lat);
      int c;
      int s;
      c   = (b >= W) ? W : int'(b);
      o   = 1'b0;
      lat = 2;
      r   = '0;
      case (sel)
         3'b000: r = b;
         3'b001: begin
            s = int'($signed(a)) + int'($signed(b));
            r = W'(s);
            o = (s > SMAX) || (s < SMIN);
         end
         3'b010: r = a & b;
         3'b011: r = a | b;
         3'b100: begin r = a << c; lat = ((c == 0) ? 1 : c) + 1; end
         3'b101: begin r = a >> c; lat = ((c == 0) ? 1 : c) + 1; end
         3'b110: begin r = W'($signed(a) >>> c); lat = ((c == 0) ? 1 : c) + 1; end
         default: begin r = W'(a * b); lat = W + 2; end
      endcase
   endfunction

   int           m_left = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_result = '0;
   logic         m_ovf = 1'b0;
   logic [W-1:0] p_result = '0;
   logic         p_ovf = 1'b0;
   logic [W-1:0] mr;
   logic         mo;
   int           ml;

   always @(posedge clk) begin
      if (rst) begin
         m_left   <= 0;
         m_done   <= 1'b0;
         m_result <= '0;
         m_ovf    <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done   <= 1'b1;
            m_result <= p_result;
            m_ovf    <= p_ovf;
         end
      end else if (bus.START) begin
         model_op(bus.SELECT, bus.DATA1, bus.DATA2, mr, mo, ml);
         p_result <= mr;
         p_ovf    <= mo;
         m_left   <= ml - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         if (bus.BUSY !== ((m_left != 0) || m_done) || bus.DONE !== m_done ||
             bus.RESULT !== m_result || bus.ZERO !== (m_result == '0) ||
             bus.OVERFLOW !== m_ovf) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t busy/done/result/zero/ovf got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                     $time, bus.BUSY, bus.DONE, bus.RESULT, bus.ZERO, bus.OVERFLOW,
                     (m_left != 0) || m_done, m_done, m_result, (m_result == '0), m_ovf);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] sel, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] exp_res,
                         input logic exp_ovf, input int exp_lat, input int inject,
                         input bit start_at_done);
      int cyc;
      bit got;
      bit busy_all;
      @(negedge clk);
      bus.START  = 1'b1;
      bus.SELECT = sel;
      bus.DATA1  = d1;
      bus.DATA2  = d2;
      @(posedge clk);
      cyc      = 0;
      got      = 1'b0;
      busy_all = 1'b1;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            bus.START  = 1'b0;
            bus.SELECT = 3'($urandom);
            bus.DATA1  = W'($urandom);
            bus.DATA2  = W'($urandom);
         end
         if (inject != 0 && cyc == inject) begin
            bus.START  = 1'b1;
            bus.SELECT = OP_AND;
         end
         if (inject != 0 && cyc == inject + 1) bus.START = 1'b0;
         if (bus.DONE) got = 1'b1;
         else if (!bus.BUSY) busy_all = 1'b0;
      end
      $display("op %s sel=%0d a=%h b=%h -> result=%h zero=%b ovf=%b after %0d cycles",
               name, sel, d1, d2, bus.RESULT, bus.ZERO, bus.OVERFLOW, cyc);
      check({name, " done_seen"}, 32'(got), 32'd1);
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " result"}, 32'(bus.RESULT), 32'(exp_res));
      check({name, " overflow"}, 32'(bus.OVERFLOW), 32'(exp_ovf));
      check({name, " zero"}, 32'(bus.ZERO), 32'(exp_res == '0));
      check({name, " busy_held"}, 32'(busy_all), 32'd1);
      if (start_at_done) begin
         bus.START  = 1'b1;
         bus.SELECT = OP_OR;
         bus.DATA1  = 8'h11;
         bus.DATA2  = 8'h22;
         @(negedge clk);
         bus.START = 1'b0;
         check({name, " start_in_finish_ignored"}, 32'(bus.BUSY), 32'd0);
      end
   endtask

   initial begin
      bit saw_done;
      rst        = 1'b1;
      bus.START  = 1'b0;
      bus.SELECT = 3'b000;
      bus.DATA1  = '0;
      bus.DATA2  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(bus.BUSY), 32'd0);
      check("reset done", 32'(bus.DONE), 32'd0);
      check("reset result", 32'(bus.RESULT), 32'd0);
      check("reset zero", 32'(bus.ZERO), 32'd1);
      check("reset overflow", 32'(bus.OVERFLOW), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      //     name         op      d1     d2     result ovf lat inj fin
      run_op("add_5_3",   OP_ADD, 8'h05, 8'h03, 8'h08, 0,  2,  0,  0);
      run_op("add_ovf",   OP_ADD, 8'h7F, 8'h01, 8'h80, 1,  2,  0,  0);
      run_op("and",       OP_AND, 8'hC3, 8'h5A, 8'h42, 0,  2,  0,  0);
      run_op("fwd_zero",  OP_FWD, 8'h5A, 8'h00, 8'h00, 0,  2,  0,  0);
      run_op("or",        OP_OR,  8'h0F, 8'hA0, 8'hAF, 0,  2,  0,  0);
      run_op("add_negov", OP_ADD, 8'h80, 8'h80, 8'h00, 1,  2,  0,  0);
      run_op("add_m1_p1", OP_ADD, 8'hFF, 8'h01, 8'h00, 0,  2,  0,  0);
      run_op("mul_m3x5",  OP_MUL, 8'hFD, 8'h05, 8'hF1, 0,  10, 0,  0);
      run_op("sra_2",     OP_SRA, 8'h90, 8'h02, 8'hE4, 0,  3,  0,  0);
      run_op("srl_9",     OP_SRL, 8'h90, 8'h09, 8'h00, 0,  9,  0,  0);
      run_op("sll_0",     OP_SLL, 8'h37, 8'h00, 8'h37, 0,  2,  0,  0);
      run_op("sll_3",     OP_SLL, 8'h37, 8'h03, 8'hB8, 0,  4,  0,  0);
      run_op("sra_ff",    OP_SRA, 8'h90, 8'hFF, 8'hFF, 0,  9,  0,  0);
      run_op("mul_m7xm6", OP_MUL, 8'hF9, 8'hFA, 8'h2A, 0,  10, 0,  0);
      run_op("mul_inj",   OP_MUL, 8'hFD, 8'h05, 8'hF1, 0,  10, 3,  0);
      run_op("add_fin",   OP_ADD, 8'h01, 8'h02, 8'h03, 0,  2,  0,  1);

      // Reset in EXEC cycle 4 of a multiply, with a competing START.
      @(negedge clk);
      bus.START  = 1'b1;
      bus.SELECT = OP_MUL;
      bus.DATA1  = 8'hFD;
      bus.DATA2  = 8'h05;
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) bus.START = 1'b0;
      end
      rst        = 1'b1;
      bus.START  = 1'b1;
      bus.SELECT = OP_ADD;
      bus.DATA1  = 8'h05;
      bus.DATA2  = 8'h03;
      @(negedge clk);
      rst       = 1'b0;
      bus.START = 1'b0;
      saw_done  = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.DONE) saw_done = 1'b1;
      end
      $display("op mul_reset aborted: done_seen=%b result=%h zero=%b", saw_done, bus.RESULT, bus.ZERO);
      check("mul_reset no_done", 32'(saw_done), 32'd0);
      check("mul_reset result", 32'(bus.RESULT), 32'd0);
      check("mul_reset zero", 32'(bus.ZERO), 32'd1);
      check("mul_reset busy", 32'(bus.BUSY), 32'd0);

      run_op("add_after", OP_ADD, 8'h05, 8'h03, 8'h08, 0,  2,  0,  0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
